// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-load arbiter: FSM state encoding,
// default sizing and the index-width helper.
package reg_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t LOAD = 2'd1;
   localparam state_t ACK  = 2'd2;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 3;

   // Number of bits needed to index n requesters (never less than 1).
   function automatic int idxw_f(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational priority picker: scans the request vector starting at
// i_start and wrapping from NREQ-1 back to 0; reports the first set bit.
module rr_priority_picker #(
   parameter int NREQ = 4,
   parameter int IDXW = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDXW-1:0] i_start,
   output logic            o_valid,
   output logic [IDXW-1:0] o_idx
);

   logic [IDXW:0] w_pos;

   // Wrapped scan from the start pointer; the first hit wins.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = {IDXW{1'b0}};
      w_pos   = {(IDXW+1){1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         w_pos = {1'b0, i_start} + (IDXW+1)'(k);
         if (w_pos >= (IDXW+1)'(NREQ)) begin
            w_pos = w_pos - (IDXW+1)'(NREQ);
         end else begin
            w_pos = w_pos;
         end
         if (!o_valid && i_req[w_pos[IDXW-1:0]]) begin
            o_valid = 1'b1;
            o_idx   = w_pos[IDXW-1:0];
         end else begin
            o_valid = o_valid;
         end
      end
   end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing one ld/in load port of a small register among
// NREQ requesters: IDLE picks a winner, LOAD pulses reg_ld, ACK pulses gnt.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (requester 0
// highest); the FSM, latency and handshake are unchanged.
module reg_load_arbiter
   import reg_arb_pkg::*;
#(
   parameter  int NREQ  = NREQ_DEF,
   parameter  int WIDTH = WIDTH_DEF,
   localparam int IDXW  = idxw_f(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       gnt,
   output logic                  reg_ld,
   output logic [WIDTH-1:0]      reg_in,
   output logic                  busy,
   output logic [IDXW-1:0]       owner
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDXW-1:0]   r_win_idx;
   logic [WIDTH-1:0]  r_data_q;
   logic [NREQ-1:0]   r_gnt;
   logic              r_reg_ld;
   logic              r_busy;
   logic [IDXW-1:0]   r_owner;

   logic [IDXW-1:0]   w_start;
   logic              w_pick_vld;
   logic [IDXW-1:0]   w_pick_idx;
   logic [WIDTH-1:0]  w_win_data;
   logic [NREQ-1:0]   w_gnt_vec;

`ifdef ARB_FIXED_PRIO_EN
   assign w_start = {IDXW{1'b0}};
`else
   logic [IDXW-1:0]   r_rr_ptr;
   logic [IDXW-1:0]   w_ptr_nxt;

   assign w_ptr_nxt = (r_win_idx == IDXW'(NREQ-1)) ? {IDXW{1'b0}} : (r_win_idx + {{(IDXW-1){1'b0}}, 1'b1});
   assign w_start   = r_rr_ptr;

   // Advance the round-robin pointer past the winner as its grant completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr <= {IDXW{1'b0}};
      end else if (r_state == ACK) begin
         r_rr_ptr <= w_ptr_nxt;
      end else begin
         r_rr_ptr <= r_rr_ptr;
      end
   end
`endif

   rr_priority_picker #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_picker (
      .i_req   (req),
      .i_start (w_start),
      .o_valid (w_pick_vld),
      .o_idx   (w_pick_idx)
   );

   // Select the winning requester's data slice and build its one-hot grant.
   always_comb begin
      w_win_data = {WIDTH{1'b0}};
      w_gnt_vec  = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick_idx == IDXW'(i)) begin
            w_win_data = req_data[i*WIDTH +: WIDTH];
         end else begin
            w_win_data = w_win_data;
         end
         w_gnt_vec[i] = (r_win_idx == IDXW'(i));
      end
   end

   // Next-state logic: requests are only looked at while idle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_pick_vld) begin
               w_state_nxt = LOAD;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LOAD:    w_state_nxt = ACK;
         ACK:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, capture and registered outputs; data_q doubles as reg_in and
   // simply holds between loads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_win_idx <= {IDXW{1'b0}};
         r_data_q  <= {WIDTH{1'b0}};
         r_gnt     <= {NREQ{1'b0}};
         r_reg_ld  <= 1'b0;
         r_busy    <= 1'b0;
         r_owner   <= {IDXW{1'b0}};
      end else begin
         r_state  <= w_state_nxt;
         r_busy   <= (w_state_nxt != IDLE);
         r_reg_ld <= (w_state_nxt == LOAD);
         if ((r_state == IDLE) && w_pick_vld) begin
            r_win_idx <= w_pick_idx;
            r_data_q  <= w_win_data;
         end else begin
            r_win_idx <= r_win_idx;
            r_data_q  <= r_data_q;
         end
         if (r_state == LOAD) begin
            r_gnt   <= w_gnt_vec;
            r_owner <= r_win_idx;
         end else begin
            r_gnt   <= {NREQ{1'b0}};
            r_owner <= r_owner;
         end
      end
   end

   assign gnt    = r_gnt;
   assign reg_ld = r_reg_ld;
   assign reg_in = r_data_q;
   assign busy   = r_busy;
   assign owner  = r_owner;

endmodule
